soc_run_monitor: RTL and testbench

//  Synthesisable end-of-run monitor for multi-core zeroriscy SoC instances (FT system).

---
 rtl/soc_run_monitor_if.sv | 37 +++
 rtl/soc_run_monitor.sv | 114 +++++++++++
 tb/tb_soc_run_monitor.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_run_monitor_if.sv
// Bundle of control, per-core completion and status signals for soc_run_monitor.
// The master side starts and clears runs and supplies core results; the slave side reports status.
interface soc_run_monitor_if #(
  parameter int NCORES     = 3,
  parameter int DATA_WIDTH = 32,
  parameter int CW         = 7
);
  logic                         fetch_enable_i;
  logic                         clear_i;
  logic [NCORES-1:0]            mem_flag_i;
  logic [NCORES*DATA_WIDTH-1:0] mem_result_i;

  logic [NCORES-1:0]            captured_o;
  logic [NCORES*DATA_WIDTH-1:0] result_o;
  logic [DATA_WIDTH-1:0]        voted_result_o;
  logic [NCORES-1:0]            agree_o;
  logic                         mismatch_o;
  logic                         busy_o;
  logic                         done_o;
  logic                         timeout_o;
  logic [CW-1:0]                cycles_o;
  logic [1:0]                   state_o;

  // Flags are level-sampled on every rising edge; there is no back-pressure,
  // so a core's flag counts only on the first RUN edge it is seen high.
  modport master (
    output fetch_enable_i, clear_i, mem_flag_i, mem_result_i,
    input  captured_o, result_o, voted_result_o, agree_o, mismatch_o,
           busy_o, done_o, timeout_o, cycles_o, state_o
  );

  modport slave (
    input  fetch_enable_i, clear_i, mem_flag_i, mem_result_i,
    output captured_o, result_o, voted_result_o, agree_o, mismatch_o,
           busy_o, done_o, timeout_o, cycles_o, state_o
  );
endinterface

// File: rtl/soc_run_monitor.sv
// End-of-run monitor: latches each core's first result, majority-votes them and
// reports done / timeout / mismatch with an on-chip RUN-cycle watchdog.
module soc_run_monitor #(
  parameter int NCORES         = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 100
) (
  input logic              clk_i,
  input logic              rst_ni,
  soc_run_monitor_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = DATA_WIDTH;
  localparam logic [CW-1:0] LAST_CYC = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_e;

  state_e               state_q, state_d;
  logic [NCORES-1:0]    cap_q, cap_d;
  logic [NCORES*DW-1:0] res_q, res_d;
  logic [CW-1:0]        cyc_q, cyc_d;

  logic [DW-1:0]        voted;
  logic [NCORES-1:0]    col;
  logic [NCORES-1:0]    agree;
  logic                 mm;

  function automatic logic majority(input logic [NCORES-1:0] v);
    int c;
    c = 0;
    for (int k = 0; k < NCORES; k++) c = c + int'(v[k]);
    return c > (NCORES / 2);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      res_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      res_q   <= res_d;
      cyc_q   <= cyc_d;
    end
  end

  // clear_i is checked before any state so it overrides start, capture and timeout.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    res_d   = res_q;
    cyc_d   = cyc_q;
    if (bus.clear_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.fetch_enable_i) begin
            state_d = S_RUN;
            cap_d   = '0;
            res_d   = '0;
            cyc_d   = '0;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NCORES; k++) begin
            if (bus.mem_flag_i[k] && !cap_q[k]) begin
              cap_d[k]           = 1'b1;
              res_d[k*DW +: DW]  = bus.mem_result_i[k*DW +: DW];
            end
          end
          if (&cap_d)                state_d = S_DONE;
          else if (cyc_q == LAST_CYC) state_d = S_TIMEOUT;
          else                        cyc_d   = cyc_q + 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Uncaptured slots hold zero, so they naturally vote 0.
  always_comb begin
    voted = '0;
    col   = '0;
    for (int b = 0; b < DW; b++) begin
      for (int k = 0; k < NCORES; k++) col[k] = res_q[k*DW + b];
      voted[b] = majority(col);
    end
  end

  always_comb begin
    mm    = 1'b0;
    agree = '0;
    for (int i = 0; i < NCORES; i++) begin
      agree[i] = cap_q[i] && (res_q[i*DW +: DW] == voted);
      for (int j = i + 1; j < NCORES; j++) begin
        if (cap_q[i] && cap_q[j] && (res_q[i*DW +: DW] != res_q[j*DW +: DW])) mm = 1'b1;
      end
    end
  end

  assign bus.captured_o     = cap_q;
  assign bus.result_o       = res_q;
  assign bus.voted_result_o = voted;
  assign bus.agree_o        = agree;
  assign bus.mismatch_o     = mm && (state_q != S_IDLE);
  assign bus.busy_o         = (state_q == S_RUN);
  assign bus.done_o         = (state_q == S_DONE);
  assign bus.timeout_o      = (state_q == S_TIMEOUT);
  assign bus.cycles_o       = cyc_q;
  assign bus.state_o        = state_q;
endmodule

// File: tb/tb_soc_run_monitor.sv
// Bench for soc_run_monitor: directed scenarios with literal expectations plus
// randomized runs compared every cycle against a behavioural model.
module tb_soc_run_monitor;
  localparam int NC = 3;
  localparam int DW = 32;
  localparam int TC = 100;
  localparam int CW = $clog2(TC + 1);

  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_TIMEOUT = 3;

  logic clk;
  logic rst_n;

  soc_run_monitor_if #(.NCORES(NC), .DATA_WIDTH(DW), .CW(CW)) bus ();

  soc_run_monitor #(.NCORES(NC), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TC)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  int              m_state;
  bit [NC-1:0]     m_cap;
  logic [DW-1:0]   m_res [NC];
  int              m_cyc;
  logic [DW-1:0]   exp_q [$];

  function automatic logic [DW-1:0] model_vote();
    logic [DW-1:0] v;
    int ones;
    v = '0;
    for (int b = 0; b < DW; b++) begin
      ones = 0;
      for (int k = 0; k < NC; k++) if (m_res[k][b]) ones++;
      v[b] = (ones > NC / 2);
    end
    return v;
  endfunction

  function automatic bit model_mismatch();
    bit r;
    r = 0;
    if (m_state == M_IDLE) return 0;
    for (int i = 0; i < NC; i++)
      for (int j = 0; j < NC; j++)
        if (i != j && m_cap[i] && m_cap[j] && m_res[i] != m_res[j]) r = 1;
    return r;
  endfunction

  function automatic logic [NC*DW-1:0] model_results();
    logic [NC*DW-1:0] r;
    for (int k = 0; k < NC; k++) r[k*DW +: DW] = m_res[k];
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_state = M_IDLE; m_cap = '0; m_cyc = 0;
        for (int k = 0; k < NC; k++) m_res[k] = '0;
      end else if (bus.clear_i) begin
        m_state = M_IDLE;
      end else if (m_state == M_IDLE) begin
        if (bus.fetch_enable_i) begin
          m_state = M_RUN; m_cap = '0; m_cyc = 0;
          for (int k = 0; k < NC; k++) m_res[k] = '0;
        end
      end else if (m_state == M_RUN) begin
        for (int k = 0; k < NC; k++)
          if (bus.mem_flag_i[k] && !m_cap[k]) begin
            m_cap[k] = 1'b1;
            m_res[k] = bus.mem_result_i[k*DW +: DW];
          end
        if (m_cap == '1) begin
          m_state = M_DONE;
          exp_q.push_back(model_vote());
        end else if (m_cyc == TC - 1) m_state = M_TIMEOUT;
        else m_cyc++;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [NC-1:0] m_agree;
  logic [DW-1:0] m_voted;
  bit prev_done = 0;

  initial begin
    forever begin
      @(negedge clk);
      m_voted = model_vote();
      for (int k = 0; k < NC; k++) m_agree[k] = m_cap[k] && (m_res[k] == m_voted);
      check("captured", 128'(bus.captured_o), 128'(m_cap));
      check("result",   128'(bus.result_o),   128'(model_results()));
      check("voted",    128'(bus.voted_result_o), 128'(m_voted));
      check("agree",    128'(bus.agree_o),    128'(m_agree));
      check("mismatch", 128'(bus.mismatch_o), 128'(model_mismatch()));
      check("busy",     128'(bus.busy_o),     128'(m_state == M_RUN));
      check("done",     128'(bus.done_o),     128'(m_state == M_DONE));
      check("timeout",  128'(bus.timeout_o),  128'(m_state == M_TIMEOUT));
      check("cycles",   128'(bus.cycles_o),   128'(m_cyc));
      if (bus.done_o && !prev_done) begin
        if (exp_q.size() == 0) check("done_vote_queued", 128'(0), 128'(1));
        else check("done_vote", 128'(bus.voted_result_o), 128'(exp_q.pop_front()));
      end
      prev_done = bus.done_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    bus.fetch_enable_i = 1'b1;
    step(1);
    bus.fetch_enable_i = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear_i = 1'b1;
    step(1);
    bus.clear_i = 1'b0;
  endtask

  task automatic set_core(input int k, input logic f, input logic [DW-1:0] v);
    bus.mem_flag_i[k] = f;
    bus.mem_result_i[k*DW +: DW] = v;
  endtask

  task automatic pulse(input logic [NC-1:0] mask, input logic [DW-1:0] v);
    for (int k = 0; k < NC; k++) if (mask[k]) set_core(k, 1'b1, v);
    step(1);
    bus.mem_flag_i = '0;
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 3))
      0: return 32'h55;
      1: return 32'h37;
      2: return 32'h55;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bus.fetch_enable_i = 0; bus.clear_i = 0; bus.mem_flag_i = '0; bus.mem_result_i = '0;
    rst_n = 1'b0;
    step(3);
    check("rst_captured", 128'(bus.captured_o), 128'(0));
    check("rst_cycles",   128'(bus.cycles_o),   128'(0));
    check("rst_status",   128'({bus.busy_o, bus.done_o, bus.timeout_o, bus.mismatch_o}), 128'(0));
    rst_n = 1'b1;
    step(1);

    // 1: all flags at cycle 10
    start_run();
    step(10);
    pulse(3'b111, 32'd55);
    check("t1_done",   128'(bus.done_o), 128'(1));
    check("t1_voted",  128'(bus.voted_result_o), 128'(55));
    check("t1_agree",  128'(bus.agree_o), 128'(3'b111));
    check("t1_mm",     128'(bus.mismatch_o), 128'(0));
    check("t1_cycles", 128'(bus.cycles_o), 128'(10));
    do_clear();

    // 2: staggered flags, core1 disagrees
    start_run();
    step(5);  pulse(3'b001, 32'h55);
    step(2);  pulse(3'b010, 32'h37);
    step(3);  pulse(3'b100, 32'h55);
    check("t2_done",  128'(bus.done_o), 128'(1));
    check("t2_voted", 128'(bus.voted_result_o), 128'(32'h55));
    check("t2_agree", 128'(bus.agree_o), 128'(3'b101));
    check("t2_mm",    128'(bus.mismatch_o), 128'(1));
    check("t2_cycles", 128'(bus.cycles_o), 128'(12));
    do_clear();
    check("t2_idle_mm", 128'(bus.mismatch_o), 128'(0));

    // 3: core2 never flags
    start_run();
    pulse(3'b011, 32'h1);
    step(98);
    check("t3_busy99", 128'(bus.busy_o), 128'(1));
    step(1);
    check("t3_timeout", 128'(bus.timeout_o), 128'(1));
    check("t3_cap",     128'(bus.captured_o), 128'(3'b011));
    check("t3_cycles",  128'(bus.cycles_o), 128'(99));
    check("t3_done",    128'(bus.done_o), 128'(0));
    step(3);
    check("t3_hold",    128'(bus.timeout_o), 128'(1));
    do_clear();

    // 4: last flag in cycle 99
    start_run();
    pulse(3'b011, 32'h2);
    step(98);
    pulse(3'b100, 32'h2);
    check("t4_done",    128'(bus.done_o), 128'(1));
    check("t4_timeout", 128'(bus.timeout_o), 128'(0));
    check("t4_cycles",  128'(bus.cycles_o), 128'(99));
    do_clear();

    // 5: held flag, result changes after capture; clear keeps data, restart wipes it
    start_run();
    set_core(0, 1'b1, 32'd5);
    step(1);
    set_core(0, 1'b1, 32'd9);
    step(3);
    check("t5_res0", 128'(bus.result_o[DW-1:0]), 128'(5));
    check("t5_cap",  128'(bus.captured_o), 128'(3'b001));
    bus.mem_flag_i = '0;
    do_clear();
    check("t5_idle", 128'(bus.busy_o), 128'(0));
    start_run();
    check("t5_restart_cap", 128'(bus.captured_o), 128'(0));
    check("t5_restart_res", 128'(bus.result_o), 128'(0));
    do_clear();

    // 6: async reset mid-RUN, then flags in IDLE
    start_run();
    pulse(3'b001, 32'hAA);
    step(3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_cap",    128'(bus.captured_o), 128'(0));
    check("t6_res",    128'(bus.result_o), 128'(0));
    check("t6_busy",   128'(bus.busy_o), 128'(0));
    check("t6_cycles", 128'(bus.cycles_o), 128'(0));
    step(1);
    rst_n = 1'b1;
    bus.mem_flag_i = 3'b111;
    step(3);
    check("t6_idle_cap", 128'(bus.captured_o), 128'(0));
    bus.mem_flag_i = '0;

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      int thr;
      thr = $urandom_range(3, 80);
      start_run();
      for (int c = 0; c < 150; c++) begin
        for (int k = 0; k < NC; k++)
          set_core(k, ($urandom_range(0, 999) < thr), pick());
        bus.fetch_enable_i = ($urandom_range(0, 9) == 0);
        bus.clear_i        = ($urandom_range(0, 199) == 0);
        step(1);
      end
      bus.mem_flag_i = '0; bus.fetch_enable_i = 0; bus.clear_i = 0;
      do_clear();
    end

    step(2);
    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
